imem_arbiter: RTL and testbench



---
 rtl/imem_pkg.sv | 17 +
 rtl/imem_starve_ctr.sv | 33 +++
 rtl/imem_arbiter.sv | 104 ++++++++++
 tb/tb_imem_arbiter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared constants and encodings for the program-memory arbiter slice.
package imem_pkg;

   localparam int unsigned AW_DEF = 8;
   localparam int unsigned DW_DEF = 16;

   typedef enum logic {
      IDLE = 1'b0,
      ACC  = 1'b1
   } state_e;

   typedef enum logic {
      GNT_CPU = 1'b0,
      GNT_DBG = 1'b1
   } grant_e;

endpackage

// File: rtl/imem_starve_ctr.sv
// Saturating count of CPU grants taken while debug waits; flags when debug must win.
module imem_starve_ctr #(
   parameter int unsigned MAX = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic inc_i,
   input  logic clr_i,
   output logic force_dbg_o
);

   localparam logic [3:0] MAX_C = 4'(MAX);

   logic [3:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (inc_i && cnt_q != MAX_C)
         cnt_d = cnt_q + 4'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign force_dbg_o = (cnt_q == MAX_C);

endmodule

// File: rtl/imem_arbiter.sv
// Two-port (CPU fetch / debug read) arbiter in front of a combinational program ROM.
// Optional IMEM_STALL_CNT_EN adds the cpu_stall_cnt output.
module imem_arbiter
   import imem_pkg::*;
#(
   parameter int unsigned AW             = AW_DEF,
   parameter int unsigned DW             = DW_DEF,
   parameter int unsigned DBG_STARVE_MAX = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cpu_req,
   input  logic [AW-1:0] cpu_addr,
   output logic          cpu_ack,
   output logic [DW-1:0] cpu_data,
   input  logic          dbg_req,
   input  logic [AW-1:0] dbg_addr,
   output logic          dbg_ack,
   output logic [DW-1:0] dbg_data,
   output logic [AW-1:0] mem_addr,
   input  logic [DW-1:0] mem_data
`ifdef IMEM_STALL_CNT_EN
   ,
   output logic [15:0]   cpu_stall_cnt
`endif
);

   state_e        state_q;
   grant_e        grant_q;
   logic [AW-1:0] mem_addr_q;
   logic          cpu_ack_q, dbg_ack_q;
   logic [DW-1:0] cpu_data_q, dbg_data_q;

   logic   grant_edge;
   logic   force_dbg;
   grant_e winner;

   assign grant_edge = (state_q == IDLE) && (cpu_req || dbg_req);
   assign winner     = (cpu_req && !(dbg_req && force_dbg)) ? GNT_CPU : GNT_DBG;

   // Starvation count only moves at grant edges; a debug win or an absent debug request resets it.
   imem_starve_ctr #(.MAX(DBG_STARVE_MAX)) u_starve (
      .clk         (clk),
      .rst_n       (rst_n),
      .inc_i       (grant_edge && winner == GNT_CPU && dbg_req),
      .clr_i       (grant_edge && (winner == GNT_DBG || !dbg_req)),
      .force_dbg_o (force_dbg)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         grant_q    <= GNT_CPU;
         mem_addr_q <= '0;
         cpu_ack_q  <= 1'b0;
         dbg_ack_q  <= 1'b0;
         cpu_data_q <= '0;
         dbg_data_q <= '0;
      end else begin
         cpu_ack_q <= 1'b0;
         dbg_ack_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (grant_edge) begin
                  grant_q    <= winner;
                  mem_addr_q <= (winner == GNT_CPU) ? cpu_addr : dbg_addr;
                  state_q    <= ACC;
               end
            end
            ACC: begin
               if (grant_q == GNT_CPU) begin
                  cpu_data_q <= mem_data;
                  cpu_ack_q  <= 1'b1;
               end else begin
                  dbg_data_q <= mem_data;
                  dbg_ack_q  <= 1'b1;
               end
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign mem_addr = mem_addr_q;
   assign cpu_ack  = cpu_ack_q;
   assign dbg_ack  = dbg_ack_q;
   assign cpu_data = cpu_data_q;
   assign dbg_data = dbg_data_q;

`ifdef IMEM_STALL_CNT_EN
   logic [15:0] stall_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         stall_q <= '0;
      else if (cpu_req && !cpu_ack_q && stall_q != 16'hFFFF)
         stall_q <= stall_q + 16'd1;
   end

   assign cpu_stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_imem_arbiter.sv
// Scoreboard bench for imem_arbiter: driver predicts grants from the arbitration rules, monitor checks acks.
module tb_imem_arbiter;

   localparam int STARVE = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cpu_req = 1'b0, dbg_req = 1'b0;
   logic [7:0]  cpu_addr = '0, dbg_addr = '0;
   logic        cpu_ack, dbg_ack;
   logic [15:0] cpu_data, dbg_data, mem_data;
   logic [7:0]  mem_addr;
   logic [15:0] rom [256];
`ifdef IMEM_STALL_CNT_EN
   logic [15:0] cpu_stall_cnt;
`endif

   imem_arbiter #(.AW(8), .DW(16), .DBG_STARVE_MAX(STARVE)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .cpu_req  (cpu_req),
      .cpu_addr (cpu_addr),
      .cpu_ack  (cpu_ack),
      .cpu_data (cpu_data),
      .dbg_req  (dbg_req),
      .dbg_addr (dbg_addr),
      .dbg_ack  (dbg_ack),
      .dbg_data (dbg_data),
      .mem_addr (mem_addr),
      .mem_data (mem_data)
`ifdef IMEM_STALL_CNT_EN
      ,
      .cpu_stall_cnt (cpu_stall_cnt)
`endif
   );

   assign mem_data = rom[mem_addr];

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   typedef struct {
      int          port;
      logic [15:0] data;
      int          cyc;
   } exp_t;

   exp_t sb[$];

   // Reference model state: consecutive CPU grants taken while debug was waiting.
   int streak = 0;

   // Called between edges while the arbiter is idle and at least one request is up.
   // Returns at the ack cycle (just after the second edge).
   task automatic grant_round(output int who);
      exp_t e;
      logic [7:0] a;
      if (cpu_req && !(dbg_req && streak == STARVE)) who = 0;
      else who = 1;
      if (who == 0 && dbg_req) streak = (streak < STARVE) ? streak + 1 : STARVE;
      else streak = 0;
      a      = (who == 0) ? cpu_addr : dbg_addr;
      e.port = who;
      e.data = rom[a];
      e.cyc  = cyc + 2;
      sb.push_back(e);
      @(posedge clk); #1;
      chk("mem_addr", 32'(mem_addr), 32'(a));
      @(posedge clk); #1;
   endtask

   logic [15:0] cpu_hold = '0, dbg_hold = '0;

   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         cpu_hold = '0;
         dbg_hold = '0;
      end else begin
         if (cpu_ack || dbg_ack) begin
            if (sb.size() == 0) begin
               chk("unexpected_ack", 32'({cpu_ack, dbg_ack}), 32'd0);
            end else begin
               e = sb.pop_front();
               chk("ack_port", 32'({cpu_ack, dbg_ack}), (e.port == 0) ? 32'd2 : 32'd1);
               chk("ack_cycle", 32'(cyc), 32'(e.cyc));
               if (e.port == 0) cpu_hold = e.data;
               else dbg_hold = e.data;
            end
         end else if (sb.size() != 0 && sb[0].cyc < cyc) begin
            e = sb.pop_front();
            chk("missing_ack", 32'(cyc), 32'(e.cyc));
         end
         chk("cpu_data", 32'(cpu_data), 32'(cpu_hold));
         chk("dbg_data", 32'(dbg_data), 32'(dbg_hold));
      end
   end

   initial begin
      int w;
      int pat[10];
      pat = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
      for (int i = 0; i < 256; i++) rom[i] = 16'($urandom);
      rom[8'h03] = 16'hABCD;

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      chk("rst_cpu_ack", 32'(cpu_ack), 32'd0);
      chk("rst_dbg_ack", 32'(dbg_ack), 32'd0);
      chk("rst_cpu_data", 32'(cpu_data), 32'd0);
      chk("rst_dbg_data", 32'(dbg_data), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      @(negedge clk); #2 rst_n = 1'b1;

      // Single CPU fetch from $03
      @(posedge clk); #1;
      cpu_req = 1'b1; cpu_addr = 8'h03;
      grant_round(w);
      chk("cpu03_ack", 32'(cpu_ack), 32'd1);
      chk("cpu03_data", 32'(cpu_data), 32'hABCD);
      cpu_req = 1'b0;

      // Back-to-back CPU fetches
      @(posedge clk); #1;
      cpu_req = 1'b1;
      for (int i = 4; i <= 6; i++) begin
         cpu_addr = 8'(i);
         grant_round(w);
      end
      cpu_req = 1'b0;

      // Both held: CPU x4 then debug, repeating
      @(posedge clk); #1;
      cpu_req = 1'b1; dbg_req = 1'b1;
      cpu_addr = 8'($urandom); dbg_addr = 8'($urandom);
      for (int i = 0; i < 10; i++) begin
         grant_round(w);
         chk("starve_pattern", 32'(w), 32'(pat[i]));
         if (w == 0) cpu_addr = 8'($urandom);
         else dbg_addr = 8'($urandom);
      end
      cpu_req = 1'b0; dbg_req = 1'b0;

      // Debug alone from $0D
      @(posedge clk); #1;
      dbg_req = 1'b1; dbg_addr = 8'h0D;
      grant_round(w);
      chk("dbg0d_data", 32'(dbg_data), 32'(rom[8'h0D]));
      dbg_req = 1'b0;

      // Randomised traffic
      for (int n = 0; n < 300; n++) begin
         if (!cpu_req && $urandom_range(0, 1) == 1) begin
            cpu_req = 1'b1; cpu_addr = 8'($urandom);
         end
         if (!dbg_req && $urandom_range(0, 2) == 0) begin
            dbg_req = 1'b1; dbg_addr = 8'($urandom);
         end
         if (!cpu_req && !dbg_req) begin
            if (streak != 0) streak = streak; // idle edges are not grant edges
            @(posedge clk); #1;
            continue;
         end
         grant_round(w);
         if (w == 0) begin
            if ($urandom_range(0, 1) == 1) cpu_req = 1'b0;
            else cpu_addr = 8'($urandom);
         end else begin
            if ($urandom_range(0, 1) == 1) dbg_req = 1'b0;
            else dbg_addr = 8'($urandom);
         end
      end
      cpu_req = 1'b0; dbg_req = 1'b0;
      repeat (3) @(posedge clk);
      #1;

      // Reset during the access cycle: abandoned, then re-arbitrated
      cpu_req = 1'b1; cpu_addr = 8'h21;
      @(posedge clk); #1;
      chk("pre_rst_mem_addr", 32'(mem_addr), 32'h21);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_mem_addr", 32'(mem_addr), 32'd0);
      chk("midrst_cpu_ack", 32'(cpu_ack), 32'd0);
      chk("midrst_cpu_data", 32'(cpu_data), 32'd0);
      chk("midrst_dbg_data", 32'(dbg_data), 32'd0);
      @(posedge clk); #1;
      chk("midrst_no_ack", 32'({cpu_ack, dbg_ack}), 32'd0);
      streak = 0;
      @(negedge clk); #2 rst_n = 1'b1;
      grant_round(w);
      chk("post_rst_data", 32'(cpu_data), 32'(rom[8'h21]));
      cpu_req = 1'b0;

      repeat (4) @(posedge clk);
      #1;
      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
